// File: rtl/sram_fill_arbiter_pkg.sv
// Shared constants and the fill-engine state encoding for the card SRAM arbiter.
`timescale 1ns/1ps
package sram_fill_arbiter_pkg;

  localparam int SRAM_ADDR_W = 20;
  localparam int SRAM_DATA_W = 8;
  localparam int FILL_LEN_W  = 20;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ARM   = 2'd1,
    ST_WRITE = 2'd2,
    ST_NEXT  = 2'd3
  } fill_state_t;

  // Next fill address; the carry out of the top bit is dropped so 0xFFFFF wraps to 0.
  function automatic logic [SRAM_ADDR_W-1:0] addr_inc(input logic [SRAM_ADDR_W-1:0] a);
    return a + 1'b1;
  endfunction

endpackage

// File: rtl/sram_fill_arbiter_if.sv
// Bus bundle between the slot register logic / fill controller and the SRAM arbiter.
// Handshake: fill_start is a single-cycle request that is accepted only while
// fill_busy is 0 (ignored otherwise); the engine answers every accepted request
// with exactly one fill_done pulse, with fill_err qualifying it in the same cycle.
// fill_abort is a level that ends any running fill on the next clock edge.
`timescale 1ns/1ps
interface sram_fill_arbiter_if #(
  parameter int ADDR_W = 20,
  parameter int DATA_W = 8,
  parameter int LEN_W  = 20
) ();

  logic              host_req;
  logic              host_we;
  logic [ADDR_W-1:0] host_addr;
  logic [DATA_W-1:0] host_wdata;

  logic              fill_start;
  logic              fill_abort;
  logic [ADDR_W-1:0] fill_base;
  logic [LEN_W-1:0]  fill_len;
  logic [DATA_W-1:0] fill_pat;

  logic [ADDR_W-1:0] ram_addr;
  logic [DATA_W-1:0] ram_wdata;
  logic              ram_cs;
  logic              ram_we;

  logic              fill_busy;
  logic              fill_done;
  logic              fill_err;

  // Observation points: engine state and the synchronised PHI1 falling edge.
  logic [1:0]        dbg_state;
  logic              dbg_phi1_fall;

  modport master (
    output host_req, host_we, host_addr, host_wdata,
    output fill_start, fill_abort, fill_base, fill_len, fill_pat,
    input  ram_addr, ram_wdata, ram_cs, ram_we,
    input  fill_busy, fill_done, fill_err,
    input  dbg_state, dbg_phi1_fall
  );

  modport slave (
    input  host_req, host_we, host_addr, host_wdata,
    input  fill_start, fill_abort, fill_base, fill_len, fill_pat,
    output ram_addr, ram_wdata, ram_cs, ram_we,
    output fill_busy, fill_done, fill_err,
    output dbg_state, dbg_phi1_fall
  );

endinterface

// File: rtl/sram_fill_arbiter_phi_sync.sv
// Brings the 6502 PHI1 into the C7M domain and derives the host / background windows.
`timescale 1ns/1ps
module sram_fill_arbiter_phi_sync (
  input  logic clk,
  input  logic rst_n,
  input  logic phi1,
  output logic phi1_s,
  output logic host_win,
  output logic bg_win,
  output logic phi1_fall
);

  logic ph_r1;
  logic ph_r2;

  // Two-flop shift register; ph_r2 also serves as the one-cycle-delayed copy for edge detect.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ph_r1 <= 1'b0;
      ph_r2 <= 1'b0;
    end else begin
      ph_r1 <= phi1;
      ph_r2 <= ph_r1;
    end
  end

  assign phi1_s    = ph_r1;
  assign host_win  = ~ph_r2;
  assign bg_win    = ph_r1 & ph_r2;
  assign phi1_fall = ph_r2 & ~ph_r1;

endmodule

// File: rtl/sram_fill_arbiter.sv
// Card SRAM arbiter: host accesses own the pins while PHI0 is high; a background fill
// engine writes one pattern byte per PHI1 phase and always yields to the host.
`timescale 1ns/1ps
module sram_fill_arbiter
  import sram_fill_arbiter_pkg::*;
#(
  parameter int ADDR_W = SRAM_ADDR_W,
  parameter int DATA_W = SRAM_DATA_W,
  parameter int LEN_W  = FILL_LEN_W
) (
  input  logic               C7M,
  input  logic               nRES,
  input  logic               PHI1,
  sram_fill_arbiter_if.slave bus
);

  fill_state_t       state;
  logic [ADDR_W-1:0] cur;
  logic [LEN_W-1:0]  rem;
  logic [DATA_W-1:0] pat;
  logic              used;
  logic              done_r;
  logic              err_r;

  logic phi1_s;
  logic host_win;
  logic bg_win;
  logic phi1_fall;

  sram_fill_arbiter_phi_sync u_phi_sync (
    .clk       (C7M),
    .rst_n     (nRES),
    .phi1      (PHI1),
    .phi1_s    (phi1_s),
    .host_win  (host_win),
    .bg_win    (bg_win),
    .phi1_fall (phi1_fall)
  );

  // Fill engine FSM with its address/length counters and the done/err pulse registers.
  always_ff @(posedge C7M or negedge nRES) begin
    if (!nRES) begin
      state  <= ST_IDLE;
      cur    <= '0;
      rem    <= '0;
      pat    <= '0;
      used   <= 1'b0;
      done_r <= 1'b0;
      err_r  <= 1'b0;
    end else begin
      done_r <= 1'b0;
      err_r  <= 1'b0;

      // One engine slot per PHI1 high phase; the slot reopens once PHI1 is seen low.
      if (!phi1_s) begin
        used <= 1'b0;
      end else if (state == ST_WRITE) begin
        used <= 1'b1;
      end

      case (state)
        ST_IDLE: begin
          // Abort has priority over a simultaneous start: nothing is latched.
          if (bus.fill_start && !bus.fill_abort) begin
            cur <= bus.fill_base;
            rem <= bus.fill_len;
            pat <= bus.fill_pat;
            if (bus.fill_len == '0) begin
              done_r <= 1'b1;
            end else begin
              state <= ST_ARM;
            end
          end
        end
        ST_ARM: begin
          if (bus.fill_abort) begin
            state  <= ST_IDLE;
            done_r <= 1'b1;
            err_r  <= 1'b1;
          end else if (bg_win && !used && !bus.host_req) begin
            state <= ST_WRITE;
          end
        end
        ST_WRITE: begin
          // The strobe cycle has already happened on the pins; an abort only ends the fill.
          if (bus.fill_abort) begin
            state  <= ST_IDLE;
            done_r <= 1'b1;
            err_r  <= 1'b1;
          end else if (bus.host_req) begin
            state <= ST_ARM;
          end else begin
            state <= ST_NEXT;
          end
        end
        ST_NEXT: begin
          if (bus.fill_abort) begin
            state  <= ST_IDLE;
            done_r <= 1'b1;
            err_r  <= 1'b1;
          end else begin
            cur <= addr_inc(cur);
            rem <= rem - 1'b1;
            if (rem == LEN_W'(1)) begin
              state  <= ST_IDLE;
              done_r <= 1'b1;
            end else begin
              state <= ST_ARM;
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  logic host_sel;
  logic eng_sel;

  // SRAM pin mux: host in its window, else the engine during its strobe cycle, else idle.
  always_comb begin
    host_sel      = bus.host_req & host_win;
    eng_sel       = (state == ST_WRITE) & ~bus.host_req;
    bus.ram_cs    = 1'b0;
    bus.ram_we    = 1'b0;
    bus.ram_addr  = '0;
    bus.ram_wdata = '0;
    if (host_sel) begin
      bus.ram_cs    = 1'b1;
      bus.ram_we    = bus.host_we;
      bus.ram_addr  = bus.host_addr;
      bus.ram_wdata = bus.host_wdata;
    end else if (eng_sel) begin
      bus.ram_cs    = 1'b1;
      bus.ram_we    = 1'b1;
      bus.ram_addr  = cur;
      bus.ram_wdata = pat;
    end
  end

  assign bus.fill_busy     = (state != ST_IDLE);
  assign bus.fill_done     = done_r;
  assign bus.fill_err      = err_r;
  assign bus.dbg_state     = state;
  assign bus.dbg_phi1_fall = phi1_fall;

endmodule

// File: tb/tb_sram_fill_arbiter.sv
// Directed bench for sram_fill_arbiter: pin-level write monitor with an expected-address
// queue, plus step-by-step checks of the fill control handshake.
`timescale 1ns/1ps
module tb_sram_fill_arbiter;

  localparam int AW = 20;
  localparam int DW = 8;
  localparam int LW = 20;

  logic C7M  = 1'b0;
  logic nRES = 1'b0;
  logic PHI1 = 1'b0;

  sram_fill_arbiter_if #(.ADDR_W(AW), .DATA_W(DW), .LEN_W(LW)) bus ();

  sram_fill_arbiter #(.ADDR_W(AW), .DATA_W(DW), .LEN_W(LW)) dut (
    .C7M  (C7M),
    .nRES (nRES),
    .PHI1 (PHI1),
    .bus  (bus.slave)
  );

  // ---------------- clock / reset ----------------
  always #5 C7M = ~C7M;

  // PHI1: seven C7M cycles per phase, edges placed 2 ns after a C7M rising edge.
  initial begin
    forever begin
      repeat (7) @(posedge C7M);
      #2 PHI1 = ~PHI1;
    end
  end

  // ---------------- scoreboard ----------------
  int checks   = 0;
  int failures = 0;
  int wr_cnt   = 0;
  int phase_wr = 0;
  logic [AW-1:0] exp_q[$];
  logic [DW-1:0] exp_pat;

  always @(posedge PHI1) phase_wr = 0;

  // Every SRAM write strobe seen on the pins is an engine write (the bench never issues host writes).
  always @(negedge C7M) begin
    if (nRES && bus.ram_cs && bus.ram_we) begin
      logic [AW-1:0] exp_a;
      wr_cnt++;
      phase_wr++;
      checks++;
      assert (phase_wr <= 1) else begin
        failures++;
        $error("FAIL phase_limit observed=%0d expected<=1", phase_wr);
      end
      checks++;
      assert (exp_q.size() != 0) else begin
        failures++;
        $error("FAIL unexpected_write observed addr=0x%0h expected no write", bus.ram_addr);
      end
      if (exp_q.size() != 0) begin
        exp_a = exp_q.pop_front();
        checks++;
        assert (bus.ram_addr === exp_a) else begin
          failures++;
          $error("FAIL wr_addr observed=0x%0h expected=0x%0h", bus.ram_addr, exp_a);
        end
        checks++;
        assert (bus.ram_wdata === exp_pat) else begin
          failures++;
          $error("FAIL wr_data observed=0x%0h expected=0x%0h", bus.ram_wdata, exp_pat);
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick(input int n);
    repeat (n) @(negedge C7M);
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Called at a falling edge; the start pulse spans exactly one rising edge.
  task automatic start_fill(input logic [AW-1:0] base, input logic [LW-1:0] len,
                            input logic [DW-1:0] pat);
    logic [AW-1:0] a;
    a = base;
    for (int i = 0; i < int'(len); i++) begin
      exp_q.push_back(a);
      a = a + 1'b1;
    end
    exp_pat        = pat;
    bus.fill_base  = base;
    bus.fill_len   = len;
    bus.fill_pat   = pat;
    bus.fill_start = 1'b1;
    @(negedge C7M);
    bus.fill_start = 1'b0;
  endtask

  task automatic wait_done(input string tag, input logic exp_err);
    int n;
    n = 0;
    while (bus.fill_done !== 1'b1 && n < 600) begin
      @(negedge C7M);
      n++;
    end
    check({tag, "_done"}, bus.fill_done, 1);
    check({tag, "_err"}, bus.fill_err, exp_err);
    @(negedge C7M);
    check({tag, "_done_pulse"}, bus.fill_done, 0);
    check({tag, "_busy_after"}, bus.fill_busy, 0);
  endtask

  task automatic wait_writes(input string tag, input int target);
    int n;
    n = 0;
    while (wr_cnt < target && n < 300) begin
      @(negedge C7M);
      #1;
      n++;
    end
    check({tag, "_reached"}, (wr_cnt >= target), 1);
  endtask

  task automatic wait_phi(input string tag, input logic v);
    int n;
    n = 0;
    while (PHI1 !== v && n < 40) begin
      @(negedge C7M);
      n++;
    end
    check(tag, PHI1, v);
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    bus.host_req   = 1'b0;
    bus.host_we    = 1'b0;
    bus.host_addr  = '0;
    bus.host_wdata = '0;
    bus.fill_start = 1'b0;
    bus.fill_abort = 1'b0;
    bus.fill_base  = '0;
    bus.fill_len   = '0;
    bus.fill_pat   = '0;
    exp_pat        = '0;

    // Reset state
    tick(3);
    check("rst_ram_cs", bus.ram_cs, 0);
    check("rst_ram_we", bus.ram_we, 0);
    check("rst_ram_addr", bus.ram_addr, 0);
    check("rst_busy", bus.fill_busy, 0);
    check("rst_done", bus.fill_done, 0);
    check("rst_err", bus.fill_err, 0);
    check("rst_state", bus.dbg_state, 0);
    nRES = 1'b1;
    tick(2);

    // 1: plain fill of four bytes
    wr_cnt = 0;
    start_fill(20'h00100, 20'd4, 8'hA5);
    check("t1_busy", bus.fill_busy, 1);
    check("t1_state_arm", bus.dbg_state, 1);
    wait_done("t1", 1'b0);
    check("t1_writes", wr_cnt, 4);
    check("t1_queue_empty", exp_q.size(), 0);

    // 2: zero length completes immediately with no writes
    wr_cnt = 0;
    start_fill(20'h00040, 20'd0, 8'h11);
    check("t2_done", bus.fill_done, 1);
    check("t2_err", bus.fill_err, 0);
    check("t2_busy", bus.fill_busy, 0);
    tick(1);
    check("t2_done_pulse", bus.fill_done, 0);
    tick(30);
    check("t2_writes", wr_cnt, 0);
    check("t2_busy_later", bus.fill_busy, 0);

    // 3: address wraps at the top of the SRAM
    wr_cnt = 0;
    start_fill(20'hFFFFE, 20'd4, 8'h3C);
    wait_done("t3", 1'b0);
    check("t3_writes", wr_cnt, 4);
    check("t3_queue_empty", exp_q.size(), 0);

    // 4: host holding the bus starves the engine until released
    wr_cnt         = 0;
    bus.host_req   = 1'b1;
    bus.host_we    = 1'b0;
    bus.host_addr  = 20'h12345;
    bus.host_wdata = 8'h66;
    start_fill(20'h00200, 20'd2, 8'h96);
    wait_phi("t4_phi_high", 1'b1);
    wait_phi("t4_phi_low", 1'b0);
    tick(3);
    check("t4_host_cs", bus.ram_cs, 1);
    check("t4_host_we", bus.ram_we, 0);
    check("t4_host_addr", bus.ram_addr, 20'h12345);
    check("t4_host_wdata", bus.ram_wdata, 8'h66);
    tick(30);
    check("t4_no_engine_write", wr_cnt, 0);
    check("t4_busy_held", bus.fill_busy, 1);
    bus.host_req = 1'b0;
    wait_done("t4", 1'b0);
    check("t4_writes", wr_cnt, 2);
    check("t4_queue_empty", exp_q.size(), 0);

    // 5: abort after the second of eight writes
    wr_cnt = 0;
    start_fill(20'h00300, 20'd8, 8'h5A);
    wait_writes("t5_two_writes", 2);
    bus.fill_abort = 1'b1;
    @(negedge C7M);
    bus.fill_abort = 1'b0;
    check("t5_done", bus.fill_done, 1);
    check("t5_err", bus.fill_err, 1);
    check("t5_write_count_ok", (wr_cnt == 2 || wr_cnt == 3), 1);
    tick(1);
    check("t5_done_pulse", bus.fill_done, 0);
    check("t5_busy_after", bus.fill_busy, 0);
    exp_q.delete();

    // 5b: start and abort together while idle -> nothing happens
    wr_cnt         = 0;
    bus.fill_base  = 20'h00700;
    bus.fill_len   = 20'd3;
    bus.fill_pat   = 8'hEE;
    bus.fill_start = 1'b1;
    bus.fill_abort = 1'b1;
    @(negedge C7M);
    bus.fill_start = 1'b0;
    bus.fill_abort = 1'b0;
    check("t5b_busy", bus.fill_busy, 0);
    check("t5b_done", bus.fill_done, 0);
    tick(30);
    check("t5b_writes", wr_cnt, 0);

    // 6: reset in the middle of a fill, then a normal fill with an ignored second start
    wr_cnt = 0;
    start_fill(20'h00400, 20'd8, 8'h77);
    wait_writes("t6_first_write", 1);
    begin
      int n;
      n = 0;
      while (bus.ram_cs !== 1'b1 && n < 60) begin
        @(posedge C7M);
        #1;
        n++;
      end
    end
    check("t6_cs_before_reset", bus.ram_cs, 1);
    nRES = 1'b0;
    #1;
    check("t6_cs_async_drop", bus.ram_cs, 0);
    check("t6_we_async_drop", bus.ram_we, 0);
    check("t6_busy_reset", bus.fill_busy, 0);
    exp_q.delete();
    tick(3);
    nRES = 1'b1;
    tick(1);
    check("t6_no_done", bus.fill_done, 0);
    check("t6_idle", bus.dbg_state, 0);
    wr_cnt = 0;
    start_fill(20'h00500, 20'd3, 8'hC3);
    bus.fill_base  = 20'h09000;
    bus.fill_len   = 20'd5;
    bus.fill_pat   = 8'hFF;
    bus.fill_start = 1'b1;
    @(negedge C7M);
    bus.fill_start = 1'b0;
    wait_done("t6", 1'b0);
    check("t6_writes", wr_cnt, 3);
    check("t6_queue_empty", exp_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
